// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port and RAM-side signals of the shared-memory arbiter
interface mem_arbiter_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 9
);
    logic                     if_req;
    logic [ADDRESS_WIDTH-1:0] if_addr;
    logic                     if_ack;
    logic [DATA_WIDTH-1:0]    if_rdata;
    logic                     dm_req;
    logic                     dm_we;
    logic [ADDRESS_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0]    dm_wdata;
    logic                     dm_ack;
    logic [DATA_WIDTH-1:0]    dm_rdata;
    logic                     mem_read;
    logic                     mem_write;
    logic [ADDRESS_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0]    mem_data_in;
    logic [DATA_WIDTH-1:0]    mem_data_out;
    logic                     busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_data_out,
        output if_ack, if_rdata, dm_ack, dm_rdata, mem_read, mem_write, mem_address, mem_data_in, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_data_out,
        input  if_ack, if_rdata, dm_ack, dm_rdata, mem_read, mem_write, mem_address, mem_data_in, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port RAM between a fetch port and a data port
module mem_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 9
) (
    input logic          Clock,
    input logic          clear,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, COMPLETE = 2'd2} state_t;

    state_t                   r_state, w_next;
    logic                     r_grant_dm, r_we, r_last_dm;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata, r_if_rdata, r_dm_rdata;
    logic                     w_start, w_pick_dm;

    // next state, grant choice (data port wins a tie only if fetch was served last) and output decode
    always_comb begin
        w_next    = IDLE;
        w_start   = 1'b0;
        w_pick_dm = bus.dm_req && (!bus.if_req || !r_last_dm);
        case (r_state)
            IDLE: begin
                w_start = bus.if_req || bus.dm_req;
                w_next  = w_start ? ACCESS : IDLE;
            end
            ACCESS:  w_next = COMPLETE;
            default: w_next = IDLE;
        endcase
        bus.busy        = r_state != IDLE;
        bus.mem_read    = r_state == ACCESS && !r_we;
        bus.mem_write   = r_state == ACCESS && r_we;
        bus.if_ack      = r_state == COMPLETE && !r_grant_dm;
        bus.dm_ack      = r_state == COMPLETE && r_grant_dm;
        bus.mem_address = r_addr;
        bus.mem_data_in = r_wdata;
        bus.if_rdata    = r_if_rdata;
        bus.dm_rdata    = r_dm_rdata;
    end

    // state register; unused encodings fall back to IDLE through the default branch above
    always_ff @(posedge Clock) begin
        if (clear)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // latch the granted request, record the last grant and capture read data on completion
    always_ff @(posedge Clock) begin
        if (clear) begin
            r_grant_dm <= 1'b0;
            r_we       <= 1'b0;
            r_last_dm  <= 1'b1;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            if (w_start) begin
                r_grant_dm <= w_pick_dm;
                r_we       <= w_pick_dm && bus.dm_we;
                r_addr     <= w_pick_dm ? bus.dm_addr : bus.if_addr;
                if (w_pick_dm)
                    r_wdata <= bus.dm_wdata;
            end
            if (r_state == COMPLETE) begin
                r_last_dm <= r_grant_dm;
                if (!r_we && r_grant_dm)
                    r_dm_rdata <= bus.mem_data_out;
                if (!r_we && !r_grant_dm)
                    r_if_rdata <= bus.mem_data_out;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
    localparam int DW = 32;
    localparam int AW = 9;

    logic Clock = 1'b0;
    logic clear = 1'b1;
    always #5 Clock = ~Clock;

    mem_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus();
    mem_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (.Clock(Clock), .clear(clear), .bus(bus));

    // synchronous-read RAM attached to the arbiter
    logic [DW-1:0] ram [0:511];
    always @(posedge Clock) begin
        if (bus.mem_write) ram[bus.mem_address] <= bus.mem_data_in;
        if (bus.mem_read) bus.mem_data_out <= ram[bus.mem_address];
    end

    logic [DW-1:0] ref_mem [0:511];
    bit            m_last_dm;
    logic [DW-1:0] m_if_rd, m_dm_rd;
    int            total = 0;
    int            bad = 0;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic model_clear();
        m_last_dm = 1'b1;
        m_if_rd   = '0;
        m_dm_rd   = '0;
    endtask

    task automatic pulse_clear();
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
    endtask

    // runs the requested transactions; a losing requester keeps req high and is served next
    task automatic serve(input bit ri, input bit rd, input bit we, input logic [AW-1:0] ai,
                         input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        bit pi, pd, gd, ew;
        logic [AW-1:0] ea;
        pi = ri;
        pd = rd;
        bus.if_req = ri;
        bus.if_addr = ai;
        bus.dm_req = rd;
        bus.dm_we = we;
        bus.dm_addr = ad;
        bus.dm_wdata = wd;
        while (pi || pd) begin
            gd = pd && (!pi || !m_last_dm);
            ew = gd && we;
            ea = gd ? ad : ai;
            tick();
            total++;
            if (bus.mem_read !== !ew || bus.mem_write !== ew || bus.mem_address !== ea || bus.busy !== 1'b1
                || (ew && bus.mem_data_in !== wd)) begin
                bad++;
                $display("FAIL access: rd=%b wr=%b addr=%h din=%h busy=%b, expected rd=%b wr=%b addr=%h din=%h busy=1",
                         bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_data_in, bus.busy, !ew, ew, ea, wd);
            end
            tick();
            total++;
            if (bus.if_ack !== !gd || bus.dm_ack !== gd || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
                bad++;
                $display("FAIL complete: if_ack=%b dm_ack=%b rd=%b wr=%b, expected if_ack=%b dm_ack=%b rd=0 wr=0",
                         bus.if_ack, bus.dm_ack, bus.mem_read, bus.mem_write, !gd, gd);
            end
            if (gd) begin
                pd = 1'b0;
                bus.dm_req = 1'b0;
                if (we) ref_mem[ad] = wd;
                else m_dm_rd = ref_mem[ad];
            end else begin
                pi = 1'b0;
                bus.if_req = 1'b0;
                m_if_rd = ref_mem[ai];
            end
            m_last_dm = gd;
            tick();
            total++;
            if (bus.if_rdata !== m_if_rd || bus.dm_rdata !== m_dm_rd || bus.busy !== 1'b0
                || bus.if_ack !== 1'b0 || bus.dm_ack !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
                bad++;
                $display("FAIL idle: if_rdata=%h dm_rdata=%h busy=%b acks=%b%b strobes=%b%b, expected if_rdata=%h dm_rdata=%h busy=0 acks=00 strobes=00",
                         bus.if_rdata, bus.dm_rdata, bus.busy, bus.if_ack, bus.dm_ack, bus.mem_read, bus.mem_write, m_if_rd, m_dm_rd);
            end
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        bus.if_req = 1'b1;
        bus.dm_req = 1'b1;
        bus.dm_we = 1'b1;
        bus.if_addr = AW'($urandom);
        bus.dm_addr = AW'($urandom);
        bus.dm_wdata = $urandom;
        tick();
        tick();
        total++;
        if ({bus.if_ack, bus.dm_ack, bus.mem_read, bus.mem_write, bus.busy} !== 5'b0
            || bus.mem_address !== '0 || bus.mem_data_in !== '0 || bus.if_rdata !== '0 || bus.dm_rdata !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ctl=%b addr=%h din=%h if_rdata=%h dm_rdata=%h, expected all zero",
                     {bus.if_ack, bus.dm_ack, bus.mem_read, bus.mem_write, bus.busy}, bus.mem_address,
                     bus.mem_data_in, bus.if_rdata, bus.dm_rdata);
        end
        clear = 1'b0;
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        model_clear();
        tick();
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b, expected 0", bus.busy);
        end
    endtask

    task automatic test_fill();
        for (int a = 0; a < 512; a++)
            serve(1'b0, 1'b1, 1'b1, '0, AW'(a), $urandom);
    endtask

    task automatic test_if_read();
        serve(1'b0, 1'b1, 1'b1, '0, 9'h010, 32'hDEADBEEF);
        pulse_clear();
        bus.if_req = 1'b1;
        bus.if_addr = 9'h010;
        tick();
        total++;
        if (bus.mem_read !== 1'b1 || bus.mem_address !== 9'h010) begin
            bad++;
            $display("FAIL if_read_strobe: rd=%b addr=%h, expected rd=1 addr=010", bus.mem_read, bus.mem_address);
        end
        tick();
        total++;
        if (bus.if_ack !== 1'b1 || bus.dm_ack !== 1'b0) begin
            bad++;
            $display("FAIL if_read_ack: if_ack=%b dm_ack=%b, expected 1 0", bus.if_ack, bus.dm_ack);
        end
        bus.if_req = 1'b0;
        tick();
        total++;
        if (bus.if_rdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL if_read_data: if_rdata=%h, expected deadbeef", bus.if_rdata);
        end
        m_if_rd = ref_mem[9'h010];
        m_last_dm = 1'b0;
    endtask

    task automatic test_dm_write_read();
        serve(1'b0, 1'b1, 1'b1, '0, 9'h1FF, 32'h12345678);
        serve(1'b0, 1'b1, 1'b0, '0, 9'h1FF, $urandom);
        total++;
        if (bus.dm_rdata !== 32'h12345678 || bus.if_rdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL dm_write_read: dm_rdata=%h if_rdata=%h, expected 12345678 deadbeef", bus.dm_rdata, bus.if_rdata);
        end
    endtask

    task automatic test_round_robin();
        bit [3:0] order;
        int k;
        bit gd;
        pulse_clear();
        order = '0;
        k = 0;
        bus.if_req = 1'b1;
        bus.dm_req = 1'b1;
        bus.dm_we = 1'b0;
        bus.if_addr = 9'h021;
        bus.dm_addr = 9'h0A7;
        for (int c = 1; c <= 12; c++) begin
            tick();
            gd = !m_last_dm;
            total++;
            if (c % 3 == 2) begin
                if (bus.if_ack !== !gd || bus.dm_ack !== gd) begin
                    bad++;
                    $display("FAIL rr_ack cycle %0d: if_ack=%b dm_ack=%b, expected %b %b", c, bus.if_ack, bus.dm_ack, !gd, gd);
                end
                order[k] = bus.dm_ack;
                k++;
                m_last_dm = gd;
                if (gd) m_dm_rd = ref_mem[9'h0A7];
                else m_if_rd = ref_mem[9'h021];
                if (c == 11) begin
                    bus.if_req = 1'b0;
                    bus.dm_req = 1'b0;
                end
            end else if (bus.if_ack !== 1'b0 || bus.dm_ack !== 1'b0 || bus.busy !== (c != 12 && c % 3 != 0)) begin
                bad++;
                $display("FAIL rr_quiet cycle %0d: if_ack=%b dm_ack=%b busy=%b", c, bus.if_ack, bus.dm_ack, bus.busy);
            end
        end
        total++;
        if (order !== 4'b1010 || bus.if_rdata !== m_if_rd || bus.dm_rdata !== m_dm_rd) begin
            bad++;
            $display("FAIL rr_order: order=%b if_rdata=%h dm_rdata=%h, expected 1010 %h %h",
                     order, bus.if_rdata, bus.dm_rdata, m_if_rd, m_dm_rd);
        end
    endtask

    task automatic test_clear_abort();
        logic [DW-1:0] w;
        bus.dm_req = 1'b1;
        bus.dm_we = 1'b0;
        bus.dm_addr = 9'h055;
        tick();
        clear = 1'b1;
        tick();
        total++;
        if ({bus.if_ack, bus.dm_ack, bus.mem_read, bus.mem_write, bus.busy} !== 5'b0
            || bus.mem_address !== '0 || bus.mem_data_in !== '0 || bus.if_rdata !== '0 || bus.dm_rdata !== '0) begin
            bad++;
            $display("FAIL abort_read: ctl=%b addr=%h din=%h if_rdata=%h dm_rdata=%h, expected all zero",
                     {bus.if_ack, bus.dm_ack, bus.mem_read, bus.mem_write, bus.busy}, bus.mem_address,
                     bus.mem_data_in, bus.if_rdata, bus.dm_rdata);
        end
        clear = 1'b0;
        bus.dm_req = 1'b0;
        model_clear();
        tick();
        total++;
        if (bus.dm_ack !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_noack: dm_ack=%b busy=%b, expected 0 0", bus.dm_ack, bus.busy);
        end
        w = $urandom;
        bus.dm_req = 1'b1;
        bus.dm_we = 1'b1;
        bus.dm_addr = 9'h0C3;
        bus.dm_wdata = w;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        bus.dm_req = 1'b0;
        model_clear();
        ref_mem[9'h0C3] = w;
        tick();
        serve(1'b0, 1'b1, 1'b0, '0, 9'h0C3, '0);
    endtask

    task automatic test_addr_hold();
        logic [AW-1:0] a;
        a = 9'h133;
        bus.dm_req = 1'b1;
        bus.dm_we = 1'b0;
        bus.dm_addr = a;
        tick();
        bus.dm_addr = ~a;
        bus.dm_wdata = $urandom;
        tick();
        total++;
        if (bus.dm_ack !== 1'b1 || bus.mem_address !== a) begin
            bad++;
            $display("FAIL addr_hold_complete: dm_ack=%b addr=%h, expected 1 %h", bus.dm_ack, bus.mem_address, a);
        end
        bus.dm_req = 1'b0;
        m_dm_rd = ref_mem[a];
        m_last_dm = 1'b1;
        tick();
        total++;
        if (bus.dm_rdata !== m_dm_rd || bus.mem_address !== a) begin
            bad++;
            $display("FAIL addr_hold_data: dm_rdata=%h addr=%h, expected %h %h", bus.dm_rdata, bus.mem_address, m_dm_rd, a);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] d;
        d = $urandom;
        serve(1'b0, 1'b1, 1'b1, '0, 9'h1FF, ~d);
        serve(1'b0, 1'b1, 1'b1, '0, 9'h000, d);
        serve(1'b1, 1'b0, 1'b0, 9'h1FF, '0, '0);
        total++;
        if (bus.if_rdata !== ~d) begin
            bad++;
            $display("FAIL wrap_hi: if_rdata=%h, expected %h", bus.if_rdata, ~d);
        end
        serve(1'b1, 1'b0, 1'b0, 9'h000, '0, '0);
        total++;
        if (bus.if_rdata !== d) begin
            bad++;
            $display("FAIL wrap_lo: if_rdata=%h, expected %h", bus.if_rdata, d);
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(1, 3);
            serve(r[0], r[1], 1'($urandom), AW'($urandom), AW'($urandom), $urandom);
        end
    endtask

    initial begin
        bus.if_req = 1'b0;
        bus.if_addr = '0;
        bus.dm_req = 1'b0;
        bus.dm_we = 1'b0;
        bus.dm_addr = '0;
        bus.dm_wdata = '0;
        test_reset();
        test_fill();
        test_if_read();
        test_dm_write_read();
        test_round_robin();
        test_clear_abort();
        test_addr_hold();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
